// File: rtl/ram_port_arbiter.sv
// Single-port main RAM arbiter: clear engine > CPU slot > byte loader, decided combinationally each cycle.
// Writes land in the cycle they are granted; CPU reads return on cpu_q two clocks after the slot; the loader waits via ld_ready.
module ram_port_arbiter #(
  parameter int          ADDR_W     = 16,
  parameter logic [7:0]  CLR_VAL    = 8'hFF,
  parameter bit          AUTO_CLEAR = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              cpu_ce,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_ad,
  input  logic [7:0]        cpu_d,
  output logic [7:0]        cpu_q,
  output logic              cpu_drop,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              auto_pend;
  logic [ADDR_W-1:0] addr_hold;
  logic [7:0]        din_hold;
  logic              cpu_rd;
  logic              rd_p1;
  logic              drop_set;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      auto_pend <= AUTO_CLEAR;
      addr_hold <= '0;
      din_hold  <= '0;
      rd_p1     <= 1'b0;
      cpu_q     <= 8'h00;
      cpu_drop  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      auto_pend <= 1'b0;
      addr_hold <= ram_addr;
      din_hold  <= ram_din;
      rd_p1     <= cpu_rd;
      // RAM registers the address at the edge after the slot; its data is taken one edge later.
      if (rd_p1)
        cpu_q <= ram_dout;
      if (drop_set)
        cpu_drop <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ram_addr  = addr_hold;
    ram_din   = din_hold;
    ram_we    = 1'b0;
    ld_ready  = 1'b0;
    clr_busy  = 1'b0;
    cpu_rd    = 1'b0;
    drop_set  = 1'b0;
    if (reset) begin
      ram_addr = '0;
      ram_din  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_ce) begin
            ram_addr = cpu_ad;
            ram_din  = cpu_d;
            ram_we   = cpu_cs & cpu_we;
            cpu_rd   = cpu_cs & ~cpu_we;
          end else if (ld_valid) begin
            ld_ready = 1'b1;
            ram_addr = ld_addr;
            ram_din  = ld_data;
            ram_we   = 1'b1;
          end
          // The request is still served as IDLE this cycle; the clear begins on the next one.
          if (clr_start || auto_pend) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
          end
        end
        CLEAR: begin
          clr_busy = 1'b1;
          ram_addr = cnt;
          ram_din  = CLR_VAL;
          ram_we   = 1'b1;
          drop_set = cpu_ce & cpu_cs;
          cnt_nxt  = cnt + CNT_ONE;
          if (cnt == {ADDR_W{1'b1}})
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, write/read scoreboards and a reference memory image.
module tb_ram_port_arbiter;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk_sys = 1'b0;
  logic          reset, clr_start, clr_busy;
  logic          cpu_ce, cpu_cs, cpu_we;
  logic [AW-1:0] cpu_ad;
  logic [7:0]    cpu_d, cpu_q;
  logic          cpu_drop;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;

  always #5 clk_sys = ~clk_sys;

  ram_port_arbiter #(.ADDR_W(AW), .CLR_VAL(8'hFF), .AUTO_CLEAR(1'b1)) dut (
    .clk_sys(clk_sys), .reset(reset), .clr_start(clr_start), .clr_busy(clr_busy),
    .cpu_ce(cpu_ce), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_ad(cpu_ad), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_drop(cpu_drop), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout)
  );

  logic [7:0] mem     [DEPTH];
  logic [7:0] mem_ref [DEPTH];

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  logic [AW+7:0] cpu_wq[$];
  logic [AW+7:0] ld_wq[$];
  logic [7:0]    rdq[$];
  logic          exp_rd_now = 1'b0;
  logic [1:0]    rd_pipe = 2'b00;
  int            busy_cycles = 0, clr_writes = 0, clr_bad = 0, viol = 0, cyc = 0;
  logic [AW-1:0] clr_model = '0;

  always @(posedge clk_sys) begin
    rd_pipe <= {rd_pipe[0], exp_rd_now};
    cyc     <= cyc + 1;
  end

  // Monitor: clear sequence, granted writes against queued expectations, delayed read data.
  always @(negedge clk_sys) begin
    if (reset) begin
      clr_model = '0;
    end else begin
      if (clr_busy) busy_cycles++;
      if (ld_ready && cpu_ce) viol++;
      if (ram_we) begin
        if (clr_busy) begin
          if (ram_addr !== clr_model || ram_din !== 8'hFF) clr_bad++;
          clr_model = clr_model + 1'b1;
          clr_writes++;
        end else if (cpu_ce) begin
          if (cpu_wq.size() == 0) chk("cpu_wr_unexpected", {ram_addr, ram_din}, 0);
          else chk("cpu_wr", {ram_addr, ram_din}, cpu_wq.pop_front());
        end else begin
          if (ld_wq.size() == 0) chk("ld_wr_unexpected", {ram_addr, ram_din}, 0);
          else chk("ld_wr", {ram_addr, ram_din}, ld_wq.pop_front());
        end
      end
      if (rd_pipe[1]) begin
        if (rdq.size() == 0) chk("cpu_rd_unexpected", cpu_q, 0);
        else chk("cpu_q", cpu_q, rdq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int mem_diff();
    int d = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== mem_ref[i]) d++;
    return d;
  endfunction

  task automatic ref_fill_ff();
    for (int i = 0; i < DEPTH; i++) mem_ref[i] = 8'hFF;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [7:0] d, input bit served);
    cpu_ce = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_ad = a; cpu_d = d;
    if (served) begin
      cpu_wq.push_back({a, d});
      mem_ref[a] = d;
    end
    tick();
    cpu_ce = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    tick();
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a);
    cpu_ce = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_ad = a;
    rdq.push_back(mem_ref[a]);
    exp_rd_now = 1'b1;
    tick();
    cpu_ce = 1'b0; cpu_cs = 1'b0; exp_rd_now = 1'b0;
    tick();
  endtask

  task automatic ld_byte(input logic [AW-1:0] a, input logic [7:0] d);
    logic acc = 1'b0;
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    ld_wq.push_back({a, d});
    mem_ref[a] = d;
    for (int t = 0; t < 8 && !acc; t++) begin
      @(negedge clk_sys);
      acc = ld_ready;
      tick();
    end
    if (!acc) chk("ld_accept_timeout", 0, 1);
  endtask

  task automatic wait_clear_done(input string tag);
    int t = 0;
    while (clr_busy && t < DEPTH + 64) begin
      tick();
      t++;
    end
    chk(tag, clr_busy, 0);
  endtask

  initial begin
    int b0, w0, e0, v0, c0;
    reset = 1'b1; clr_start = 1'b0;
    cpu_ce = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_ad = '0; cpu_d = '0;
    ld_valid = 1'b1; ld_addr = 12'h123; ld_data = 8'h42;
    for (int i = 0; i < DEPTH; i++) mem_ref[i] = 8'h00;
    repeat (3) tick();
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_cpu_q", cpu_q, 0);
    chk("rst_cpu_drop", cpu_drop, 0);
    chk("rst_clr_busy", clr_busy, 0);
    ld_valid = 1'b0;

    // Auto clear after reset release
    b0 = busy_cycles; w0 = clr_writes; e0 = clr_bad;
    ref_fill_ff();
    reset = 1'b0;
    tick();
    chk("auto_clr_start", clr_busy, 1);
    wait_clear_done("auto_clr_end");
    chk("auto_clr_len", busy_cycles - b0, DEPTH);
    chk("auto_clr_writes", clr_writes - w0, DEPTH);
    chk("auto_clr_seq", clr_bad - e0, 0);
    chk("auto_clr_mem", mem_diff(), 0);
    chk("post_clr_cpu_q", cpu_q, 0);

    // CPU write then read with 2-clock latency
    cpu_wr(12'h234, 8'h5A, 1'b1);
    chk("idle_ram_we", ram_we, 0);
    chk("idle_addr_hold", ram_addr, 12'h234);
    cpu_ce = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b0; cpu_ad = 12'h234;
    rdq.push_back(mem_ref[12'h234]); exp_rd_now = 1'b1;
    tick();
    cpu_ce = 1'b0; cpu_cs = 1'b0; exp_rd_now = 1'b0;
    chk("cpu_q_early", cpu_q, 8'h00);
    tick();
    chk("cpu_q_2clk", cpu_q, 8'h5A);
    cpu_ce = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b1; cpu_d = 8'h77;
    tick();
    cpu_ce = 1'b0; cpu_we = 1'b0;
    repeat (3) tick();
    chk("cs0_cpu_q_hold", cpu_q, 8'h5A);

    // Loader stream with interleaved CPU slots
    v0 = viol; c0 = cyc;
    fork
      begin
        for (int k = 0; k < 256; k++) ld_byte(12'h500 + 12'(k), 8'(k));
        ld_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 64; j++) begin
          cpu_wr(12'h700 + 12'(j), 8'(j) ^ 8'h3C, 1'b1);
          cpu_rd(12'h234);
        end
      end
    join
    chk("ld_throughput", (cyc - c0) <= 520, 1);
    chk("ld_rdy_vs_ce", viol - v0, 0);
    chk("ld_mem", mem_diff(), 0);

    // CPU write during clear is dropped; clr_start during clear ignored
    b0 = busy_cycles;
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    ref_fill_ff();
    chk("clr_req_busy", clr_busy, 1);
    repeat (100) tick();
    cpu_wr(12'h010, 8'hAA, 1'b0);
    tick();
    chk("cpu_drop_set", cpu_drop, 1);
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    wait_clear_done("drop_clr_end");
    chk("clr_no_restart_len", busy_cycles - b0, DEPTH);
    chk("drop_mem_0010", mem[12'h010], 8'hFF);
    chk("drop_mem", mem_diff(), 0);
    chk("cpu_drop_sticky", cpu_drop, 1);

    // Reset aborts a clear at cnt = 100
    for (int i = 0; i < 16; i++) ld_byte(12'h060 + 12'(i), 8'h20 + 8'(i));
    for (int i = 0; i < 16; i++) ld_byte(12'h800 + 12'(i), 8'hC0 + 8'(i));
    ld_valid = 1'b0;
    tick();
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) mem_ref[i] = 8'hFF;
    tick();
    chk("abort_clr_busy", clr_busy, 0);
    chk("abort_ram_we", ram_we, 0);
    repeat (2) tick();
    chk("abort_mem_0064", mem[12'h064], 8'h24);
    chk("abort_mem", mem_diff(), 0);
    chk("abort_cpu_drop", cpu_drop, 0);
    reset = 1'b0;
    ref_fill_ff();
    tick();
    chk("reauto_busy", clr_busy, 1);
    wait_clear_done("reauto_clr_end");
    chk("reauto_mem", mem_diff(), 0);

    // Simultaneous clr_start, cpu_ce and ld_valid in IDLE
    clr_start = 1'b1;
    cpu_ce = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_ad = 12'h0AB; cpu_d = 8'h3C;
    ld_valid = 1'b1; ld_addr = 12'h0CD; ld_data = 8'h99;
    cpu_wq.push_back({12'h0AB, 8'h3C});
    @(negedge clk_sys);
    chk("sim_ld_ready", ld_ready, 0);
    chk("sim_ram_we", ram_we, 1);
    chk("sim_ram_addr", ram_addr, 12'h0AB);
    chk("sim_clr_busy_now", clr_busy, 0);
    tick();
    clr_start = 1'b0; cpu_ce = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; ld_valid = 1'b0;
    chk("sim_clr_next", clr_busy, 1);
    ref_fill_ff();
    wait_clear_done("sim_clr_end");
    chk("sim_mem", mem_diff(), 0);

    repeat (4) tick();
    chk("cpu_wq_empty", cpu_wq.size(), 0);
    chk("ld_wq_empty", ld_wq.size(), 0);
    chk("rdq_empty", rdq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
